// File: rtl/alu_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : alu_serial_tx
//  Purpose  : Serialises a parallel ALU result word onto a single line.
//             Frame = start bit, DATA_W data bits LSB first, optional even
//             parity bit, stop bit. Parallel side uses valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module alu_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CYC_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   shift_d;
    logic                parity_q;
    logic [CYC_W-1:0]    cyc_q;
    logic [BIT_W-1:0]    bit_q;
    logic                tx_q;
    logic                busy_q;
    logic                done_q;
    logic                in_ready_q;
    logic                slot_end;
    logic                accept;

    // Bit-slot boundary, next shift value and handshake qualifier
    always_comb begin
        slot_end = (cyc_q == CYC_LAST);
        shift_d  = shift_q >> 1;
        accept   = in_valid && in_ready_q;
    end

    // Frame sequencer; every output is driven from a register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            cyc_q      <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            // done is a single-cycle strobe, raised only on the STOP exit
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        shift_q    <= in_data;
                        parity_q   <= ^in_data;
                        state_q    <= S_START;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        cyc_q      <= '0;
                        bit_q      <= '0;
                    end
                end
                S_START: begin
                    if (slot_end) begin
                        cyc_q   <= '0;
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                S_DATA: begin
                    if (slot_end) begin
                        cyc_q   <= '0;
                        shift_q <= shift_d;
                        if (bit_q == BIT_LAST) begin
                            bit_q <= '0;
                            if (PARITY_EN != 0) begin
                                state_q <= S_PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                            tx_q  <= shift_d[0];
                        end
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                S_PARITY: begin
                    if (slot_end) begin
                        cyc_q   <= '0;
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                S_STOP: begin
                    if (slot_end) begin
                        cyc_q      <= '0;
                        state_q    <= S_IDLE;
                        tx_q       <= 1'b1;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    tx_q       <= 1'b1;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    cyc_q      <= '0;
                    bit_q      <= '0;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign in_ready = in_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_serial_tx
//  Purpose  : Self-checking bench for alu_serial_tx. Words to be sent are
//             queued as they are driven; a cycle-level reference of the frame
//             timing pops them on accept and checks tx/busy/done/in_ready
//             every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_serial_tx;

    localparam int DATA_W    = 8;
    localparam int CPB       = 4;
    localparam int PAR       = 1;
    localparam int SLOTS     = 2 + DATA_W + PAR;
    localparam int FRAME_CYC = SLOTS * CPB;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tx;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] sb_q[$];

    // reference state: 0 idle, 1 frame in progress, 2 done cycle
    int              m_phase = 0;
    int              m_cnt   = 0;
    logic [SLOTS-1:0] m_frame = '1;
    logic            m_acc   = 1'b0;

    alu_serial_tx #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CPB),
        .PARITY_EN   (PAR)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference: compare the current cycle, then predict the next one
    always @(negedge clk) begin
        logic e_tx, e_busy, e_done, e_rdy;
        logic [DATA_W-1:0] w;
        case (m_phase)
            1:       begin e_tx = m_frame[m_cnt / CPB]; e_busy = 1'b1; e_done = 1'b0; e_rdy = 1'b0; end
            2:       begin e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b1; e_rdy = 1'b1; end
            default: begin e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b1; end
        endcase
        chk("tx", {31'd0, tx}, {31'd0, e_tx});
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        chk("done", {31'd0, done}, {31'd0, e_done});
        chk("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});

        m_acc = 1'b0;
        if (rst) begin
            m_phase = 0;
            m_cnt   = 0;
        end else if (m_phase != 1 && in_valid) begin
            chk("sb_avail", {31'd0, (sb_q.size() > 0)}, 32'd1);
            w = (sb_q.size() > 0) ? sb_q.pop_front() : in_data;
            m_frame = {1'b1, ^w, w, 1'b0};
            m_phase = 1;
            m_cnt   = 0;
            m_acc   = 1'b1;
        end else if (m_phase == 1) begin
            if (m_cnt == FRAME_CYC - 1) m_phase = 2;
            else m_cnt++;
        end else begin
            m_phase = 0;
        end
    end

    task automatic send(input logic [DATA_W-1:0] d);
        bit ok = 0;
        sb_q.push_back(d);
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk); #1;
            if (m_acc) ok = 1;
        end
        chk("accept_seen", {31'd0, m_acc}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && m_phase == 1; i++) begin
            @(posedge clk); #1;
        end
        chk("frame_end", {31'd0, (m_phase != 1)}, 32'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h12;
        cycles(2);
        rst      = 1'b0;
        in_valid = 1'b0;
        cycles(3);

        // basic frame and odd-count parity
        send(8'hA5);
        wait_idle();
        cycles(3);
        send(8'h07);
        wait_idle();
        cycles(3);

        // back-to-back: second word held until the done cycle
        send(8'h3C);
        send(8'hC3);
        wait_idle();
        cycles(3);

        // valid pulse while busy must be ignored
        send(8'h00);
        cycles(10);
        in_data  = 8'hFF;
        in_valid = 1'b1;
        cycles(1);
        in_valid = 1'b0;
        wait_idle();
        cycles(6);

        // reset during data bit 3
        send(8'h55);
        for (int i = 0; i < 100 && !(m_phase == 1 && m_cnt == 17); i++) cycles(1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(4);
        send(8'h81);
        wait_idle();
        cycles(3);

        // a few random words
        for (int k = 0; k < 3; k++) begin
            send(DATA_W'($urandom));
            wait_idle();
            cycles(2);
        end

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
